soc_io_bridge: RTL and testbench
================================

// Module: soc_io_bridge
// PURPOSE
//   Memory-mapped IO bridge between the processor data bus and the RAM. It replaces
//   direct LED-from-x10 wiring and the tied-off TXD line.
//   - Decodes an IO page and gates RAM writes for IO accesses.
//   - Muxes read data back to the processor.
//   - Owns an LED register and a FIFO-buffered 8N1 UART transmitter.
// PARAMETERS
//   CLK_FREQ_HZ     27000000  core clock frequency after the clock block
//   BAUD            115200    UART bit rate; DIV = CLK_FREQ_HZ/BAUD (integer, >= 2)
//   NUM_LEDS        6         width of LEDS
//   LED_ACTIVE_LOW  1         1: LEDS = ~led_q; 0: LEDS = led_q
//   IO_BIT          22        mem_addr bit that selects the IO page
//   TX_FIFO_DEPTH   4         UART TX FIFO entries; power of 2, >= 2
// PORTS
//   clk        in   1         core clock (single clock domain)
//   reset      in   1         synchronous, active-high reset
//   mem_addr   in   32        processor byte address
//   mem_wdata  in   32        processor write data
//   mem_wmask  in   4         processor byte write mask
//   mem_rstrb  in   1         processor read strobe
//   mem_rdata  out  32        read data returned to the processor
//   ram_rdata  in   32        read data from RAM (1-cycle synchronous latency)
//   ram_wmask  out  4         write mask forwarded to RAM
//   LEDS       out  NUM_LEDS  board LEDs
//   TXD        out  1         UART serial output, idles high
// BEHAVIOUR
//   Decode
//   - is_io = mem_addr[IO_BIT].
//   - ram_wmask = is_io ? 4'b0 : mem_wmask (combinational).
//   - IO register offset = mem_addr[7:2]: 1=LED (RW), 2=UART_DATA (W), 4=UART_STATUS (R).
//     Any other offset reads 0; writes to it are ignored.
//   Reads (1-cycle latency, matching RAM)
//   - On mem_rstrb: register sel_io_q <= is_io and io_rdata_q <= selected IO register.
//   - mem_rdata = sel_io_q ? io_rdata_q : ram_rdata.
//   - LED reads as {0, led_q}.
//   - UART_STATUS reads as {0, count[log2(DEPTH):0] at [7:4], ovf[2], busy[1], full[0]}.
//     busy = FIFO non-empty OR FSM not IDLE.
//   - A STATUS read clears ovf one cycle later. If a dropped push lands in the same
//     cycle as the clear, ovf stays set.
//   Writes
//   - A write is an IO write when is_io && mem_wmask[0]; only byte lane 0 is decoded.
//   - LED: led_q <= mem_wdata[NUM_LEDS-1:0].
//   - UART_DATA: push mem_wdata[7:0] if !full. If full, drop the byte and set ovf.
//   - full and empty are evaluated from pre-edge state. A push when full is dropped
//     even if a pop happens in the same cycle.
//   - Simultaneous push and pop when non-empty: count unchanged, data order preserved.
//   TX FSM (states IDLE, START, DATA, STOP; baud counter bcnt counts 0..DIV-1)
//   - IDLE: TXD=1. If FIFO non-empty: pop into shreg, bcnt=0, go to START.
//   - START: TXD=0 for DIV cycles, then DATA with bit index 0.
//   - DATA: TXD=shreg[idx] for DIV cycles, LSB first. After idx 7, go to STOP.
//   - STOP: TXD=1 for DIV cycles, then IDLE.
//   - One frame = 10*DIV cycles, plus 1 IDLE cycle between back-to-back frames.
//   - TXD is registered. The first start-bit cycle appears 2 clocks after the push edge.
//   Reset (synchronous, all state)
//   - led_q=0 (so LEDS all 1 when LED_ACTIVE_LOW=1).
//   - FIFO emptied; ovf=0; sel_io_q=0; io_rdata_q=0; FSM=IDLE; TXD=1.
//   - Reset during a frame aborts it; TXD is 1 from the next edge. Queued bytes are lost.
// STRUCTURE
//   - Package soc_io_pkg: IO offset constants (LED, UART_DATA, UART_STATUS), status
//     bit positions, IO_BIT default.
//   - Sub-module uart_tx: FSM, baud counter, shift register. Interface is
//     clk/reset/data/valid/ready/TXD; it pops when ready.
//   - FIFO and decode live inline in soc_io_bridge.
// TESTING (bench with CLK_FREQ_HZ=10, BAUD=1 -> DIV=10, TX_FIFO_DEPTH=4)
//   1. Reset release -> LEDS=6'h3F, TXD=1, read STATUS -> 0.
//   2. Write 0x15 to LED (0x400004) -> LEDS=6'h2A next cycle; read-back returns 0x15;
//      ram_wmask=0 during the write.
//   3. Write 0xA5 to UART_DATA -> TXD low 2 clocks later for 10 cycles, then
//      1,0,1,0,0,1,0,1 (10 cycles each), then stop 1.
//   4. Burst of 5 writes 0x41..0x45 with no gaps -> first pops at once, rest queue.
//      All 5 transmitted in order; STATUS mid-burst shows count and busy=1, ovf=0.
//   5. 6 writes in consecutive cycles -> 6th dropped, ovf=1. STATUS read returns
//      ovf=1, then the next read returns ovf=0.
//   6. Assert reset mid-DATA bit 3 -> TXD=1 next edge, STATUS=0, no further frames.
//      A RAM read at 0x0000100 returns ram_rdata unchanged.

Source files
------------

// File: rtl/soc_io_pkg.sv
`default_nettype none
// ============================================================================
// Module  : soc_io_pkg
// Brief   : IO page offsets, UART status bit positions and TX FSM states.
// Revision: 1.0 - initial release
// ============================================================================
package soc_io_pkg;

    localparam int unsigned c_io_bit_default = 22;

    // Word offsets within the IO page (mem_addr[7:2])
    localparam logic [5:0] c_off_led         = 6'd1;
    localparam logic [5:0] c_off_uart_data   = 6'd2;
    localparam logic [5:0] c_off_uart_status = 6'd4;

    localparam int unsigned c_st_full      = 0;
    localparam int unsigned c_st_busy      = 1;
    localparam int unsigned c_st_ovf       = 2;
    localparam int unsigned c_st_count_lsb = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/soc_io_bridge_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx
// Brief   : 8N1 serial transmitter; pops a byte whenever idle and valid.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx
    import soc_io_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       txd_o
);

    localparam int unsigned BW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] c_bcnt_max = BW'(DIV - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q, txd_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            bcnt_q  <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        txd_d   = 1'b1;
        unique case (state_q)
            TX_IDLE: begin
                if (valid_i) begin
                    shreg_d = data_i;
                    bcnt_d  = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                txd_d = 1'b0;
                if (bcnt_q == c_bcnt_max) begin
                    bcnt_d  = '0;
                    idx_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                txd_d = shreg_q[idx_q];
                if (bcnt_q == c_bcnt_max) begin
                    bcnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (bcnt_q == c_bcnt_max) begin
                    bcnt_d  = '0;
                    state_d = TX_IDLE;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // txd_q reflects the previous cycle's state, hence the one-clock lag.
    assign ready_o = (state_q == TX_IDLE);
    assign busy_o  = (state_q != TX_IDLE);
    assign txd_o   = txd_q;

endmodule
`default_nettype wire

// File: rtl/soc_io_bridge.sv
`default_nettype none
// ============================================================================
// Module  : soc_io_bridge
// Brief   : IO page decode, read-data mux, LED register and FIFO-fed UART TX.
// Revision: 1.0 - initial release
// ============================================================================
module soc_io_bridge
    import soc_io_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 27000000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned NUM_LEDS       = 6,
    parameter bit          LED_ACTIVE_LOW = 1'b1,
    parameter int unsigned IO_BIT         = c_io_bit_default,
    parameter int unsigned TX_FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wmask,
    input  logic                mem_rstrb,
    output logic [31:0]         mem_rdata,
    input  logic [31:0]         ram_rdata,
    output logic [3:0]          ram_wmask,
    output logic [NUM_LEDS-1:0] LEDS,
    output logic                TXD
);

    localparam int unsigned DIV = CLK_FREQ_HZ / BAUD;
    localparam int unsigned AW  = $clog2(TX_FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam logic [CW-1:0] c_depth = CW'(TX_FIFO_DEPTH);

    logic          w_is_io, w_io_wr, w_push_req, w_push, w_drop, w_pop;
    logic          w_full, w_empty, w_tx_ready, w_tx_busy, w_rd_stat;
    logic [5:0]    w_off;
    logic [31:0]   w_status, w_io_rdata;
    logic          w_unused;

    logic [NUM_LEDS-1:0] led_q;
    logic [7:0]          fifo_q [TX_FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d, rd_stat_q;
    logic                sel_io_q;
    logic [31:0]         io_rdata_q;

    assign w_is_io    = mem_addr[IO_BIT];
    assign w_off      = mem_addr[7:2];
    assign ram_wmask  = w_is_io ? 4'b0000 : mem_wmask;
    assign w_io_wr    = w_is_io && mem_wmask[0];
    assign w_push_req = w_io_wr && (w_off == c_off_uart_data);
    assign w_full     = (count_q == c_depth);
    assign w_empty    = (count_q == '0);
    assign w_push     = w_push_req && !w_full;
    assign w_drop     = w_push_req && w_full;
    assign w_pop      = !w_empty && w_tx_ready;
    assign w_rd_stat  = mem_rstrb && w_is_io && (w_off == c_off_uart_status);
    assign count_d    = count_q + CW'(w_push) - CW'(w_pop);
    // A drop coinciding with the delayed clear wins, so no overflow goes unseen.
    assign ovf_d      = w_drop ? 1'b1 : (rd_stat_q ? 1'b0 : ovf_q);
    assign w_unused   = ^{mem_addr, mem_wdata, mem_wmask};

    always_comb begin
        w_status = '0;
        w_status[c_st_full] = w_full;
        w_status[c_st_busy] = !w_empty || w_tx_busy;
        w_status[c_st_ovf]  = ovf_q;
        w_status[c_st_count_lsb +: CW] = count_q;
    end

    always_comb begin
        w_io_rdata = '0;
        case (w_off)
            c_off_led:         w_io_rdata[NUM_LEDS-1:0] = led_q;
            c_off_uart_status: w_io_rdata = w_status;
            default:           w_io_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_stat_q  <= 1'b0;
            sel_io_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            if (w_io_wr && (w_off == c_off_led)) begin
                led_q <= mem_wdata[NUM_LEDS-1:0];
            end
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rd_stat_q <= w_rd_stat;
            if (mem_rstrb) begin
                sel_io_q   <= w_is_io;
                io_rdata_q <= w_io_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= mem_wdata[7:0];
        end
    end

    assign mem_rdata = sel_io_q ? io_rdata_q : ram_rdata;

    generate
        if (LED_ACTIVE_LOW) begin : g_led_active_low
            assign LEDS = ~led_q;
        end else begin : g_led_active_high
            assign LEDS = led_q;
        end
    endgenerate

    uart_tx #(
        .DIV (DIV)
    ) u_uart_tx (
        .clk     (clk),
        .reset   (reset),
        .data_i  (fifo_q[rd_ptr_q]),
        .valid_i (!w_empty),
        .ready_o (w_tx_ready),
        .busy_o  (w_tx_busy),
        .txd_o   (TXD)
    );

endmodule
`default_nettype wire

// File: tb/tb_soc_io_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_soc_io_bridge
// Brief   : Directed bench for soc_io_bridge with DIV=10 and a 4-entry FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module tb_soc_io_bridge;

    localparam logic [31:0] c_a_led    = 32'h0040_0004;
    localparam logic [31:0] c_a_uart   = 32'h0040_0008;
    localparam logic [31:0] c_a_unmap  = 32'h0040_000C;
    localparam logic [31:0] c_a_status = 32'h0040_0010;
    localparam logic [31:0] c_a_ram    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, ram_rdata;
    logic [3:0]  mem_wmask, ram_wmask;
    logic        mem_rstrb;
    logic [5:0]  LEDS;
    logic        TXD;

    int n_checks = 0;
    int n_fail   = 0;

    soc_io_bridge #(
        .CLK_FREQ_HZ    (10),
        .BAUD           (1),
        .NUM_LEDS       (6),
        .LED_ACTIVE_LOW (1'b1),
        .IO_BIT         (22),
        .TX_FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .ram_rdata (ram_rdata),
        .ram_wmask (ram_wmask),
        .LEDS      (LEDS),
        .TXD       (TXD)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mask);
        mem_addr  = addr;
        mem_wdata = data;
        mem_wmask = mask;
        @(negedge clk);
        mem_wmask = 4'b0000;
    endtask

    task automatic io_read(input logic [31:0] addr, output logic [31:0] data);
        mem_addr  = addr;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        data = mem_rdata;
    endtask

    // Entered on the negedge of frame cycle 'first'; leaves on cycle 99 (last stop cycle).
    task automatic check_frame(input logic [7:0] b, input int first);
        logic exp;
        for (int c = first; c < 100; c++) begin
            if (c != first) @(negedge clk);
            if (c < 10)      exp = 1'b0;
            else if (c < 90) exp = b[(c - 10) / 10];
            else             exp = 1'b1;
            check($sformatf("txd_%02h_c%0d", b, c), {31'd0, TXD}, {31'd0, exp});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          low_cnt;

        reset     = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        mem_rstrb = 1'b0;
        ram_rdata = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1. Reset state
        check("rst_leds", {26'd0, LEDS}, 32'h3F);
        check("rst_txd", {31'd0, TXD}, 32'd1);
        check("rst_rdata_ram", mem_rdata, 32'hCAFE_F00D);
        io_read(c_a_status, rd);
        check("rst_status", rd, 32'h0);

        // 2. LED write / readback, RAM write gating
        mem_addr  = c_a_led;
        mem_wdata = 32'h15;
        mem_wmask = 4'b0001;
        #1;
        check("io_wr_ram_wmask", {28'd0, ram_wmask}, 32'h0);
        @(negedge clk);
        mem_wmask = 4'b0000;
        check("led_leds", {26'd0, LEDS}, 32'h2A);
        io_read(c_a_led, rd);
        check("led_readback", rd, 32'h15);
        io_write(c_a_led, 32'h3F, 4'b0010);
        check("led_lane1_ignored", {26'd0, LEDS}, 32'h2A);
        io_read(c_a_unmap, rd);
        check("unmapped_read", rd, 32'h0);

        // 3. Single byte frame
        io_write(c_a_uart, 32'hA5, 4'b0001);
        check("a5_pre0", {31'd0, TXD}, 32'd1);
        @(negedge clk);
        check("a5_pre1", {31'd0, TXD}, 32'd1);
        @(negedge clk);
        check_frame(8'hA5, 0);
        @(negedge clk);
        check("a5_idle", {31'd0, TXD}, 32'd1);

        // 4. Burst of five; first pops immediately, four queue
        for (int i = 0; i < 5; i++) begin
            mem_addr  = c_a_uart;
            mem_wdata = 32'h41 + i;
            mem_wmask = 4'b0001;
            @(negedge clk);
        end
        mem_wmask = 4'b0000;
        io_read(c_a_status, rd);
        check("burst_status", rd, 32'h43);
        check_frame(8'h41, 3);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("burst_gap%0d", k), {31'd0, TXD}, 32'd1);
            @(negedge clk);
            check_frame(8'h41 + 8'(k), 0);
        end
        @(negedge clk);
        io_read(c_a_status, rd);
        check("burst_done_status", rd, 32'h0);

        // 5. Overflow: sixth consecutive write is dropped
        for (int i = 0; i < 6; i++) begin
            mem_addr  = c_a_uart;
            mem_wdata = 32'h61 + i;
            mem_wmask = 4'b0001;
            @(negedge clk);
        end
        mem_wmask = 4'b0000;
        io_read(c_a_status, rd);
        check("ovf_status_set", rd, 32'h47);
        @(negedge clk);
        io_read(c_a_status, rd);
        check("ovf_status_clr", rd, 32'h43);

        rd = 32'hFFFF_FFFF;
        for (int t = 0; t < 1000 && rd != 32'h0; t++) begin
            io_read(c_a_status, rd);
        end
        check("drain_status", rd, 32'h0);

        // 6. Reset mid data bit 3; queued bytes are lost
        io_write(c_a_uart, 32'h07, 4'b0001);
        io_write(c_a_uart, 32'h33, 4'b0001);
        io_write(c_a_uart, 32'h55, 4'b0001);
        repeat (45) @(negedge clk);
        check("mid_bit3_txd", {31'd0, TXD}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_txd", {31'd0, TXD}, 32'd1);
        check("abort_leds", {26'd0, LEDS}, 32'h3F);
        reset = 1'b0;
        io_read(c_a_status, rd);
        check("abort_status", rd, 32'h0);
        low_cnt = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (TXD !== 1'b1) low_cnt++;
        end
        check("no_frames_after_reset", low_cnt, 0);

        ram_rdata = 32'h1234_5678;
        io_read(c_a_ram, rd);
        check("ram_read", rd, 32'h1234_5678);
        mem_addr  = c_a_ram;
        mem_wmask = 4'b1010;
        #1;
        check("ram_wmask_pass", {28'd0, ram_wmask}, 32'hA);
        @(negedge clk);
        mem_wmask = 4'b0000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
